sys_led_monitor: RTL
====================

// Module: sys_led_monitor
// PURPOSE
//   Parametrised debug/LED front end of the MIPS system top. Selects one of NUM_CH debug
//   channels (registers, PC, ALU result, ...) onto SYS_leds with direct/hold/auto-scan modes.
//   Drives a heartbeat CLK_led and produces a stretched, synchronously released core reset.
// PARAMETERS
//   NUM_CH      8           number of debug channels (>=2)
//   CH_W        32          width of each channel
//   LED_W       27          LED bus width; must satisfy LED_W > SEL_W
//   SEL_W       $clog2(NUM_CH)  select width (derived, localparam)
//   CLK_DIV     25_000_000  cycles per CLK_led toggle (>=1)
//   SCAN_DIV    50_000_000  cycles per auto-scan channel step (>=1)
//   RST_STRETCH 4           cycles core_reset stays high after SYS_reset falls (>=1)
// PORTS
//   clk             in   1            system clock
//   SYS_reset       in   1            async, active-high reset
//   SYS_output_sel  in   SEL_W        requested channel
//   SYS_mode        in   2            00 DIRECT, 01 HOLD, 10 SCAN, 11 = DIRECT
//   ch_data         in   NUM_CH*CH_W  channel k at [k*CH_W +: CH_W]
//   ch_valid        in   NUM_CH       per-channel update strobe (used in HOLD)
//   SYS_leds        out  LED_W        {cur_ch, shown data[LED_W-SEL_W-1:0]}
//   CLK_led         out  1            heartbeat
//   cur_ch          out  SEL_W        channel currently displayed
//   core_reset      out  1            reset to CPU core
// BEHAVIOUR
//   Reset: one clock, clk; SYS_reset asynchronous, active-high. While high: SYS_leds=0,
//     CLK_led=0, cur_ch=0, core_reset=1, state=DIRECT, all counters 0.
//   core_reset: asserts asynchronously with SYS_reset; deasserts on the RST_STRETCH-th rising
//     edge after SYS_reset falls (count restarts if SYS_reset re-asserts mid-stretch).
//   FSM (registered, takes SYS_mode one cycle late): DIRECT, HOLD, SCAN; any state -> state of
//     SYS_mode each cycle; code 11 -> DIRECT.
//   DIRECT: cur_ch <= SYS_output_sel; SYS_leds <= {sel, ch_data[sel]} -> 1-cycle latency.
//   HOLD: cur_ch <= SYS_output_sel; data field updates only in cycles where ch_valid[sel]=1,
//     otherwise frozen; index field always tracks cur_ch.
//   SCAN: on entry cur_ch <= SYS_output_sel, scan counter cleared; every SCAN_DIV cycles
//     cur_ch <= (cur_ch==NUM_CH-1) ? 0 : cur_ch+1; data field refreshed every cycle.
//   Out-of-range select (sel >= NUM_CH, non-power-of-2 NUM_CH): cur_ch and SYS_leds hold.
//   Width: if CH_W < LED_W-SEL_W, data zero-extended; else truncated to low bits.
//   CLK_led: counter 0..CLK_DIV-1; toggles when counter wraps; free-running out of reset.
//   Mode change and select change in the same cycle: new mode applies with new select.
// CONFIGURATION
//   SYS_LED_AUTOSCAN_EN defined: SCAN mode and scan counter present as above.
//   Not defined: scan counter removed; SYS_mode=10 behaves exactly as DIRECT.
// STRUCTURE
//   sys_pkg: mode enum (MODE_DIRECT/HOLD/SCAN), mode code localparams, clog2-safe width helper.
//   Sub-module sys_tick_gen (param DIV): counter + 1-cycle tick, sync clear; instanced for
//     CLK_led and scan step. Top holds FSM, channel mux, LED register, reset stretcher.
// TESTING (NUM_CH=8, CH_W=32, LED_W=27, CLK_DIV=4, SCAN_DIV=3, RST_STRETCH=3)
//   Reset 4 cycles, release -> outputs 0 during reset; core_reset falls on 3rd edge after release.
//   DIRECT, sel=5, ch5=32'h00ABCDEF -> next cycle SYS_leds=27'h5ABCDEF, cur_ch=5.
//   HOLD, sel=2, ch2 changes 0x11->0x22 with ch_valid[2]=0 -> data stays 0x11; valid=1 -> 0x22.
//   SCAN from sel=6 -> cur_ch 6,7,0,1 each 3 cycles (wrap checked); macro off -> stays 6.
//   Free run 16 cycles after reset -> CLK_led toggles every 4 cycles, 0->1 first at cycle 4.
//   SYS_reset pulse mid-SCAN (cur_ch=3) -> immediate async clear, DIRECT, stretch restarts.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared definitions for the system LED/debug monitor.
//   sys_mode_e    : decoded display mode (DIRECT / HOLD / SCAN)
//   MODE_CODE_*   : raw 2-bit SYS_mode encodings
//   cnt_w()       : counter width for a 0..n-1 counter, never below 1 bit
package sys_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_HOLD   = 2'b01,
    MODE_SCAN   = 2'b10
  } sys_mode_e;

  localparam logic [1:0] MODE_CODE_DIRECT     = 2'b00;
  localparam logic [1:0] MODE_CODE_HOLD       = 2'b01;
  localparam logic [1:0] MODE_CODE_SCAN       = 2'b10;
  localparam logic [1:0] MODE_CODE_ALT_DIRECT = 2'b11;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sys_tick_gen.sv
// Free-running modulo-DIV counter producing a one-cycle tick on its last count.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset (counter to 0)
//   clr  : synchronous clear, restarts the count at 0 and suppresses the tick
//   tick : high for one cycle every DIV cycles (every cycle when DIV=1)
module sys_tick_gen
  import sys_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CW   = cnt_w(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_p1;

  assign tick = (cnt_p1 == LAST) && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (clr || (cnt_p1 == LAST)) begin
      cnt_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

endmodule

// File: rtl/sys_led_monitor.sv
// Debug/LED front end of the MIPS system top.
// Selects one of NUM_CH debug channels onto SYS_leds, with DIRECT, HOLD and
// (optionally) auto-SCAN display modes, drives a heartbeat LED and produces a
// stretched core reset.
// Optional feature: define SYS_LED_AUTOSCAN_EN to build the SCAN mode and its
// step counter; without it, SYS_mode=10 behaves exactly as DIRECT.
// Ports:
//   clk            : system clock
//   SYS_reset      : asynchronous active-high reset
//   SYS_output_sel : requested channel
//   SYS_mode       : 00 DIRECT, 01 HOLD, 10 SCAN, 11 DIRECT
//   ch_data        : channel k at [k*CH_W +: CH_W]
//   ch_valid       : per-channel update strobe, used in HOLD
//   SYS_leds       : {cur_ch, shown data (zero-extended or truncated)}
//   CLK_led        : heartbeat, toggles every CLK_DIV cycles
//   cur_ch         : channel currently displayed
//   core_reset     : CPU core reset, released RST_STRETCH edges after SYS_reset
module sys_led_monitor
  import sys_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 8,
  parameter  int unsigned CH_W        = 32,
  parameter  int unsigned LED_W       = 27,
  parameter  int unsigned CLK_DIV     = 25_000_000,
  parameter  int unsigned SCAN_DIV    = 50_000_000,
  parameter  int unsigned RST_STRETCH = 4,
  localparam int unsigned SEL_W       = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   SYS_reset,
  input  logic [SEL_W-1:0]       SYS_output_sel,
  input  logic [1:0]             SYS_mode,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]      ch_valid,
  output logic [LED_W-1:0]       SYS_leds,
  output logic                   CLK_led,
  output logic [SEL_W-1:0]       cur_ch,
  output logic                   core_reset
);

  localparam int unsigned DW   = LED_W - SEL_W;
  localparam int unsigned RS_W = cnt_w(RST_STRETCH);

  sys_mode_e        mode_p1;
  sys_mode_e        mode_nxt;
  logic [DW-1:0]    dat_p1;
  logic [SEL_W-1:0] cur_nxt;
  logic [SEL_W-1:0] cur_wrap;
  logic             upd_dat;
  logic             sel_ok;
  logic [CH_W-1:0]  ch_arr [NUM_CH];
  logic [CH_W-1:0]  ch_word;
  logic [DW-1:0]    dat_fit;
  logic             hb_tick;
  logic [RS_W-1:0]  rs_cnt_p1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_arr[g] = ch_data[g*CH_W +: CH_W];
  end

  // Non-power-of-2 channel counts leave select codes with no channel behind them.
  assign sel_ok   = (32'(SYS_output_sel) < NUM_CH);
  assign cur_wrap = (cur_ch == SEL_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;

  // Mode decode: the FSM simply follows SYS_mode, one cycle late.
  always_comb begin
    mode_nxt = MODE_DIRECT;
    case (SYS_mode)
      MODE_CODE_HOLD: mode_nxt = MODE_HOLD;
`ifdef SYS_LED_AUTOSCAN_EN
      MODE_CODE_SCAN: mode_nxt = MODE_SCAN;
`endif
      default:        mode_nxt = MODE_DIRECT;
    endcase
  end

`ifdef SYS_LED_AUTOSCAN_EN
  logic scan_tick;

  // Held in clear outside SCAN so the first step comes SCAN_DIV cycles after entry.
  sys_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk  (clk),
    .rst  (SYS_reset),
    .clr  (mode_p1 != MODE_SCAN),
    .tick (scan_tick)
  );
`endif

  // Next displayed channel and whether the data field refreshes; decisions use
  // the incoming mode so a mode and select change in one cycle act together.
  always_comb begin
    cur_nxt = cur_ch;
    upd_dat = 1'b0;
    case (mode_nxt)
      MODE_HOLD: begin
        if (sel_ok) begin
          cur_nxt = SYS_output_sel;
          upd_dat = ch_valid[SYS_output_sel];
        end
      end
`ifdef SYS_LED_AUTOSCAN_EN
      MODE_SCAN: begin
        if (mode_p1 != MODE_SCAN) begin
          if (sel_ok) begin
            cur_nxt = SYS_output_sel;
            upd_dat = 1'b1;
          end
        end else begin
          if (scan_tick) begin
            cur_nxt = cur_wrap;
          end
          upd_dat = 1'b1;
        end
      end
`endif
      default: begin
        if (sel_ok) begin
          cur_nxt = SYS_output_sel;
          upd_dat = 1'b1;
        end
      end
    endcase
  end

  assign ch_word = ch_arr[cur_nxt];

  if (CH_W >= DW) begin : g_trunc
    assign dat_fit = ch_word[DW-1:0];
  end else begin : g_zext
    assign dat_fit = {{(DW - CH_W){1'b0}}, ch_word};
  end

  // ---- stage p1: mode, displayed channel and LED data registers ----
  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      mode_p1 <= MODE_DIRECT;
      cur_ch  <= '0;
      dat_p1  <= '0;
    end else begin
      mode_p1 <= mode_nxt;
      cur_ch  <= cur_nxt;
      if (upd_dat) begin
        dat_p1 <= dat_fit;
      end
    end
  end

  assign SYS_leds = {cur_ch, dat_p1};

  // Heartbeat
  sys_tick_gen #(
    .DIV (CLK_DIV)
  ) u_hb_tick (
    .clk  (clk),
    .rst  (SYS_reset),
    .clr  (1'b0),
    .tick (hb_tick)
  );

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      CLK_led <= 1'b0;
    end else if (hb_tick) begin
      CLK_led <= ~CLK_led;
    end
  end

  // Reset stretcher: asserts with SYS_reset, releases on the RST_STRETCH-th
  // edge afterwards; a new SYS_reset pulse restarts the count via the async clear.
  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      rs_cnt_p1  <= '0;
      core_reset <= 1'b1;
    end else if (core_reset) begin
      if (rs_cnt_p1 == RS_W'(RST_STRETCH - 1)) begin
        core_reset <= 1'b0;
      end else begin
        rs_cnt_p1 <= rs_cnt_p1 + 1'b1;
      end
    end
  end

endmodule
